keccak_stream_absorber: RTL and testbench

- SHA3-512 sponge front-end: the receiving side of the HMAC controller's block-streaming interface.
- Accepts 32-bit words per block into a 576-bit rate buffer and applies SHA3 padding on the final block.
- Issues each block to the Keccak-f permutation core, then returns the 512-bit digest.
- Sits between hmac_controller's streaming port and the permutation core; the PUF one-shot path is outside this block.

---
 rtl/keccak_stream_absorber.sv | 227 ++++++++++++++++++++++
 tb/tb_keccak_stream_absorber.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_stream_absorber.sv
// keccak_stream_absorber
// SHA3-512 sponge front-end. Collects 32-bit words from the HMAC controller's
// block-streaming port into a 576-bit rate buffer. Applies SHA3 padding on the
// final block and hands each block to the Keccak-f core. Captures the digest
// that the core returns.
//
// Ports
//   clk, reset (sync, active-low)
//   mode_block, start_block, words_in_block : block open request
//   block_word, block_word_valid, block_last : word stream
//   busy, buffer_full                        : flow control to the controller
//   perm_start/perm_block/perm_first/perm_final, perm_ready/perm_done/perm_digest
//                                            : permutation core handshake
//   hash_out, hash_ready                     : digest result
//
// Optional: define KECCAK_STREAM_ERR_CHK_EN to add the err_sticky output.
//
// state        | meaning
// S_IDLE       | waiting for start_block in streaming mode
// S_FILL       | block open, accepting words
// S_ISSUE      | block closed, waiting for perm_ready to launch it
// S_PERM_WAIT  | permutation running, waiting for perm_done
// S_PAD        | padding-only block after a full (18-word) final block
// S_DIGEST     | one-cycle hash_ready, message closed

module keccak_stream_absorber #(
    parameter int RATE_WORDS  = 18,
    parameter int DIGEST_BITS = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode_block,
    input  logic                     start_block,
    input  logic [5:0]               words_in_block,
    input  logic [31:0]              block_word,
    input  logic                     block_word_valid,
    input  logic                     block_last,
    output logic                     busy,
    output logic                     buffer_full,
    output logic                     perm_start,
    output logic [32*RATE_WORDS-1:0] perm_block,
    output logic                     perm_first,
    output logic                     perm_final,
    input  logic                     perm_ready,
    input  logic                     perm_done,
    input  logic [DIGEST_BITS-1:0]   perm_digest,
    output logic [DIGEST_BITS-1:0]   hash_out,
    output logic                     hash_ready
`ifdef KECCAK_STREAM_ERR_CHK_EN
    ,
    output logic                     err_sticky
`endif
);

    localparam int RB = 32 * RATE_WORDS;
    localparam int CW = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RATE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_ISSUE, S_PERM_WAIT, S_PAD, S_DIGEST
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          limit_q, limit_d;
    logic [CW-1:0]          count_q, count_d;
    logic [RB-1:0]          rate_q, rate_d;
    logic                   last_seen_q, last_seen_d;
    logic                   msg_open_q, msg_open_d;
    logic                   perm_start_q, perm_start_d;
    logic [RB-1:0]          perm_block_q, perm_block_d;
    logic                   perm_first_q, perm_first_d;
    logic                   perm_final_q, perm_final_d;
    logic [DIGEST_BITS-1:0] hash_out_q, hash_out_d;
    logic                   hash_ready_q, hash_ready_d;

    // SHA3 pad10*1 with domain bits: 0x06 right after the n data words,
    // 0x80 in the last byte of the rate. Both may hit the same word.
    function automatic logic [RB-1:0] pad_block(input logic [RB-1:0] blk,
                                                input logic [CW-1:0] n);
        logic [RB-1:0] p;
        p = blk;
        for (int i = 0; i < RATE_WORDS; i++) begin
            if (n == CW'(i)) p[32*i +: 8] = p[32*i +: 8] | 8'h06;
        end
        p[RB-1 -: 8] = p[RB-1 -: 8] | 8'h80;
        return p;
    endfunction

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        count_d      = count_q;
        rate_d       = rate_q;
        last_seen_d  = last_seen_q;
        msg_open_d   = msg_open_q;
        perm_start_d = 1'b0;
        perm_block_d = perm_block_q;
        perm_first_d = perm_first_q;
        perm_final_d = perm_final_q;
        hash_out_d   = hash_out_q;
        hash_ready_d = 1'b0;
        busy         = 1'b0;
        buffer_full  = 1'b1;

        case (state_q)
            S_IDLE: begin
                buffer_full = 1'b0;
                if (start_block && mode_block) begin
                    limit_d = (words_in_block == 6'd0 || int'(words_in_block) > RATE_WORDS)
                              ? FULL_CNT : CW'(words_in_block);
                    count_d     = '0;
                    rate_d      = '0;
                    last_seen_d = 1'b0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                busy        = 1'b1;
                buffer_full = (count_q == limit_q);
                if (block_word_valid && !buffer_full) begin
                    for (int i = 0; i < RATE_WORDS; i++) begin
                        if (count_q == CW'(i)) rate_d[32*i +: 32] = block_word;
                    end
                    count_d = count_q + 1'b1;
                    if ((count_q + 1'b1) == limit_q || block_last) begin
                        last_seen_d = block_last;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (perm_ready) begin
                    perm_start_d = 1'b1;
                    perm_block_d = (last_seen_q && count_q < FULL_CNT)
                                   ? pad_block(rate_q, count_q) : rate_q;
                    perm_first_d = !msg_open_q;
                    perm_final_d = last_seen_q && (count_q < FULL_CNT);
                    msg_open_d   = 1'b1;
                    state_d      = S_PERM_WAIT;
                end
            end
            S_PERM_WAIT: begin
                if (perm_done) begin
                    if (perm_final_q) begin
                        hash_out_d   = perm_digest;
                        hash_ready_d = 1'b1;
                        state_d      = S_DIGEST;
                    end else if (last_seen_q && count_q == FULL_CNT) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAD: begin
                if (perm_ready) begin
                    perm_start_d = 1'b1;
                    perm_block_d = pad_block('0, '0);
                    perm_first_d = 1'b0;
                    perm_final_d = 1'b1;
                    state_d      = S_PERM_WAIT;
                end
            end
            S_DIGEST: begin
                msg_open_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            limit_q      <= '0;
            count_q      <= '0;
            rate_q       <= '0;
            last_seen_q  <= 1'b0;
            msg_open_q   <= 1'b0;
            perm_start_q <= 1'b0;
            perm_block_q <= '0;
            perm_first_q <= 1'b0;
            perm_final_q <= 1'b0;
            hash_out_q   <= '0;
            hash_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            count_q      <= count_d;
            rate_q       <= rate_d;
            last_seen_q  <= last_seen_d;
            msg_open_q   <= msg_open_d;
            perm_start_q <= perm_start_d;
            perm_block_q <= perm_block_d;
            perm_first_q <= perm_first_d;
            perm_final_q <= perm_final_d;
            hash_out_q   <= hash_out_d;
            hash_ready_q <= hash_ready_d;
        end
    end

    assign perm_start = perm_start_q;
    assign perm_block = perm_block_q;
    assign perm_first = perm_first_q;
    assign perm_final = perm_final_q;
    assign hash_out   = hash_out_q;
    assign hash_ready = hash_ready_q;

`ifdef KECCAK_STREAM_ERR_CHK_EN
    logic err_sticky_q, err_sticky_d;

    always_comb begin
        err_sticky_d = err_sticky_q
                     | (block_word_valid && !busy)
                     | (start_block && state_q != S_IDLE)
                     | (perm_done && state_q != S_PERM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) err_sticky_q <= 1'b0;
        else        err_sticky_q <= err_sticky_d;
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_keccak_stream_absorber.sv
module tb_keccak_stream_absorber;
    logic         clk = 1'b0;
    logic         reset;
    logic         mode_block, start_block;
    logic [5:0]   words_in_block;
    logic [31:0]  block_word;
    logic         block_word_valid, block_last;
    logic         busy, buffer_full, perm_start;
    logic [575:0] perm_block;
    logic         perm_first, perm_final;
    logic         perm_ready, perm_done;
    logic [511:0] perm_digest, hash_out;
    logic         hash_ready;
`ifdef KECCAK_STREAM_ERR_CHK_EN
    logic         err_sticky;
`endif

    always #5 clk = ~clk;

    keccak_stream_absorber dut (
        .clk(clk), .reset(reset), .mode_block(mode_block), .start_block(start_block),
        .words_in_block(words_in_block), .block_word(block_word),
        .block_word_valid(block_word_valid), .block_last(block_last),
        .busy(busy), .buffer_full(buffer_full), .perm_start(perm_start),
        .perm_block(perm_block), .perm_first(perm_first), .perm_final(perm_final),
        .perm_ready(perm_ready), .perm_done(perm_done), .perm_digest(perm_digest),
        .hash_out(hash_out), .hash_ready(hash_ready)
`ifdef KECCAK_STREAM_ERR_CHK_EN
        , .err_sticky(err_sticky)
`endif
    );

    int checks = 0, failures = 0;
    int hash_pulses = 0;
    bit ready_en = 1'b1, core_busy = 1'b0, use_a5 = 1'b0, gaps = 1'b0, msg_first = 1'b1;
    logic [511:0] last_dig = '0;
    logic [31:0]  blk_words [18];
    byte unsigned mbytes [72];
    logic [575:0] exp_blk[$], cap_blk[$];
    bit           exp_first[$], exp_final[$], cap_first[$], cap_final[$];

    typedef struct {
        int          n_words;
        int          pat;
        int          exp_perms;
        int          pad_idx;
        logic [31:0] pad_word;
        logic [31:0] w17;
    } vec_t;

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Permutation core stand-in: captures every launched block, answers after
    // a random latency, checks the block is held stable meanwhile.
    initial begin
        int lat;
        logic [511:0] dig;
        perm_done = 1'b0; perm_digest = '0; perm_ready = 1'b0;
        forever begin
            @(negedge clk);
            perm_ready = ready_en && !core_busy;
            if (perm_start) begin
                perm_ready = 1'b0;
                core_busy  = 1'b1;
                cap_blk.push_back(perm_block);
                cap_first.push_back(perm_first);
                cap_final.push_back(perm_final);
                lat = $urandom_range(1, 4);
                repeat (lat) @(negedge clk);
                chk("stable_block", perm_block, cap_blk[$]);
                chk("stable_flags", {perm_first, perm_final}, {cap_first[$], cap_final[$]});
                dig = use_a5 ? {64{8'hA5}} : {16{$urandom}};
                if (perm_final) last_dig = dig;
                perm_digest = dig;
                perm_done   = 1'b1;
                @(negedge clk);
                perm_done = 1'b0;
                core_busy = 1'b0;
                perm_ready = ready_en;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (hash_ready) begin
                hash_pulses++;
                chk("hash_out", hash_out, last_dig);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Message-level reference: data bytes, then 0x06, zero fill, 0x80 in byte 71.
    task automatic emit(input bit fin);
        logic [575:0] b;
        for (int j = 0; j < 72; j++) b[8*j +: 8] = mbytes[j];
        exp_blk.push_back(b);
        exp_first.push_back(msg_first);
        exp_final.push_back(fin);
        msg_first = 1'b0;
    endtask

    task automatic model_block(input int nw, input bit last);
        int nb = 0;
        for (int j = 0; j < 72; j++) mbytes[j] = 8'h00;
        for (int i = 0; i < nw; i++)
            for (int j = 0; j < 4; j++) begin
                mbytes[nb] = blk_words[i][8*j +: 8];
                nb++;
            end
        if (last && nw == 18) begin
            emit(1'b0);
            for (int j = 0; j < 72; j++) mbytes[j] = 8'h00;
            nb = 0;
        end
        if (last) begin
            mbytes[nb] = mbytes[nb] | 8'h06;
            mbytes[71] = mbytes[71] | 8'h80;
        end
        emit(last);
        if (last) msg_first = 1'b1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || buffer_full || core_busy || perm_start) && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 500) chk("idle_timeout", {busy, buffer_full}, 0);
    endtask

    task automatic wait_hash(input int target);
        int g = 0;
        while (hash_pulses < target && g < 800) begin
            @(posedge clk); #1;
            g++;
        end
        chk("hash_pulse_seen", hash_pulses, target);
        repeat (3) @(posedge clk);
        #1;
        chk("hash_pulse_single", hash_pulses, target);
    endtask

    task automatic send_block(input int wib, input int nw, input bit last);
        int sent = 0, guard = 0;
        bit acc;
        wait_idle();
        mode_block = 1'b1; start_block = 1'b1; words_in_block = 6'(wib);
        @(posedge clk); #1;
        start_block = 1'b0;
        while (sent < nw && guard < 300) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                block_word_valid = 1'b0; block_last = 1'b0;
            end else begin
                block_word_valid = 1'b1;
                block_word       = blk_words[sent];
                block_last       = last && (sent == nw - 1);
            end
            acc = block_word_valid && busy && !buffer_full;
            @(posedge clk); #1;
            if (acc) sent++;
            guard++;
        end
        block_word_valid = 1'b0; block_last = 1'b0;
        if (guard >= 300) chk("send_timeout", sent, nw);
    endtask

    task automatic clear_q();
        exp_blk.delete(); exp_first.delete(); exp_final.delete();
        cap_blk.delete(); cap_first.delete(); cap_final.delete();
    endtask

    task automatic compare_queues(input string name);
        int n;
        chk({name, "_perm_count"}, cap_blk.size(), exp_blk.size());
        n = (cap_blk.size() < exp_blk.size()) ? cap_blk.size() : exp_blk.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_block"}, cap_blk[i], exp_blk[i]);
            chk({name, "_first"}, cap_first[i], exp_first[i]);
            chk({name, "_final"}, cap_final[i], exp_final[i]);
        end
        clear_q();
    endtask

    task automatic run_message(input int n_words, input int pat, input int wib);
        int k = 0, nw, target;
        bit last;
        target = hash_pulses + 1;
        while (k < n_words) begin
            nw   = (n_words - k > 18) ? 18 : n_words - k;
            last = (k + nw == n_words);
            for (int i = 0; i < nw; i++) begin
                case (pat)
                    0: blk_words[i] = 32'(k + i + 1);
                    1: blk_words[i] = 32'hFFFF_FFFF;
                    2: blk_words[i] = (k < 18) ? 32'h3636_3636 : 32'(k + i + 1);
                    default: blk_words[i] = $urandom;
                endcase
            end
            model_block(nw, last);
            send_block(wib, nw, last);
            k += nw;
        end
        wait_hash(target);
        wait_idle();
    endtask

    initial begin
        vec_t tbl [6];
        logic [575:0] lastb;
        int hp, nb, wib, lim, nw;
        bit last;

        tbl[0] = '{16, 0, 1, 16, 32'h0000_0006, 32'h8000_0000};
        tbl[1] = '{18, 1, 2, 0,  32'h0000_0006, 32'h8000_0000};
        tbl[2] = '{21, 2, 2, 3,  32'h0000_0006, 32'h8000_0000};
        tbl[3] = '{17, 0, 1, 17, 32'h8000_0006, 32'h8000_0006};
        tbl[4] = '{1,  3, 1, 1,  32'h0000_0006, 32'h8000_0000};
        tbl[5] = '{36, 3, 3, 0,  32'h0000_0006, 32'h8000_0000};

        reset = 1'b0; mode_block = 1'b0; start_block = 1'b0; words_in_block = '0;
        block_word = '0; block_word_valid = 1'b0; block_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_buffer_full", buffer_full, 0);
        chk("rst_perm_start", perm_start, 0);
        chk("rst_hash_ready", hash_ready, 0);
        chk("rst_perm_block", perm_block, 0);
        chk("rst_hash_out", hash_out, 0);
        chk("rst_flags", {perm_first, perm_final}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // start_block without streaming mode is ignored
        start_block = 1'b1; words_in_block = 6'd4;
        @(posedge clk); #1;
        start_block = 1'b0;
        @(posedge clk); #1;
        chk("mode0_ignored", busy, 0);

        for (int t = 0; t < 6; t++) begin
            use_a5 = (t == 0);
            run_message(tbl[t].n_words, tbl[t].pat, (t % 2 == 1) ? 0 : 18);
            chk("tv_perms", cap_blk.size(), tbl[t].exp_perms);
            if (cap_blk.size() > 0) begin
                lastb = cap_blk[$];
                chk("tv_pad_word", lastb[32*tbl[t].pad_idx +: 32], tbl[t].pad_word);
                chk("tv_word17", lastb[575 -: 32], tbl[t].w17);
                chk("tv_first", cap_first[0], 1);
                chk("tv_final", cap_final[$], 1);
            end
            if (t == 0) chk("tv_hash_a5", hash_out, {64{8'hA5}});
            compare_queues("tv");
        end
        use_a5 = 1'b0;

        // perm_ready withheld after the block closes
        ready_en = 1'b0;
        for (int i = 0; i < 5; i++) blk_words[i] = 32'h100 + 32'(i);
        hp = hash_pulses;
        model_block(5, 1'b1);
        send_block(18, 5, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                mode_block = 1'b1; start_block = 1'b1; words_in_block = 6'd3;
            end else begin
                start_block = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_busy", busy, 0);
            chk("hold_full", buffer_full, 1);
            chk("hold_no_start", cap_blk.size() + int'(perm_start), 0);
        end
        start_block = 1'b0;
        ready_en = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_start", perm_start, 1);
        wait_hash(hp + 1);
        wait_idle();
        compare_queues("hold");

        // short non-last blocks (words_in_block < 18) then a last block
        clear_q();
        hp = hash_pulses;
        for (int i = 0; i < 5; i++) blk_words[i] = $urandom;
        model_block(5, 1'b0);
        send_block(5, 5, 1'b0);
        for (int i = 0; i < 2; i++) blk_words[i] = $urandom;
        model_block(2, 1'b1);
        send_block(9, 2, 1'b1);
        wait_hash(hp + 1);
        wait_idle();
        compare_queues("short");

        // reset in the middle of a block aborts the message
        clear_q();
        for (int i = 0; i < 5; i++) blk_words[i] = $urandom;
        hp = hash_pulses;
        send_block(18, 5, 1'b0);
        chk("abort_open", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_full", buffer_full, 0);
        chk("abort_hash_out", hash_out, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_hash", hash_pulses, hp);
        chk("abort_no_perm", cap_blk.size(), 0);
        clear_q();
        msg_first = 1'b1;
        run_message(3, 3, 18);
        if (cap_first.size() > 0) chk("abort_next_first", cap_first[0], 1);
        compare_queues("abort_next");

        // randomized messages with random block sizes and stream gaps
        gaps = 1'b1;
        for (int m = 0; m < 25; m++) begin
            nb = $urandom_range(1, 3);
            hp = hash_pulses;
            for (int b = 0; b < nb; b++) begin
                wib  = $urandom_range(0, 40);
                lim  = (wib == 0 || wib > 18) ? 18 : wib;
                last = (b == nb - 1);
                nw   = last ? $urandom_range(1, lim) : lim;
                if (last && $urandom_range(0, 3) == 0) nw = lim;
                for (int i = 0; i < nw; i++) blk_words[i] = $urandom;
                model_block(nw, last);
                send_block(wib, nw, last);
            end
            wait_hash(hp + 1);
            wait_idle();
            compare_queues("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
